// File: rtl/lsu_mem_ctrl_pkg.sv
// Encodings shared by the load/store unit and the control unit that drives mem_size.
package lsu_mem_ctrl_pkg;

   localparam logic [1:0] MEM_B = 2'b00;
   localparam logic [1:0] MEM_H = 2'b01;
   localparam logic [1:0] MEM_W = 2'b10;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_REQ  = 2'd1,
      ST_WAIT = 2'd2,
      ST_DONE = 2'd3
   } lsu_state_e;

   // Size 11 is reserved, so it is rejected like a misaligned access.
   function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] off);
      case (size)
         MEM_B:   return 1'b0;
         MEM_H:   return off[0];
         MEM_W:   return off != 2'b00;
         default: return 1'b1;
      endcase
   endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Byte-lane steering for stores and shift/extend for loads; purely combinational.
module lsu_lane_align
   import lsu_mem_ctrl_pkg::*;
(
   input  logic [1:0]  st_size,
   input  logic [1:0]  st_off,
   input  logic [31:0] st_data,
   output logic [3:0]  st_be,
   output logic [31:0] st_wdata,
   input  logic [1:0]  ld_size,
   input  logic [1:0]  ld_off,
   input  logic        ld_sign,
   input  logic [31:0] ld_word,
   output logic [31:0] ld_data
);

   logic [31:0] ld_shift;

   always_comb begin
      st_be    = 4'b0000;
      st_wdata = st_data;
      case (st_size)
         MEM_B: begin
            st_be    = 4'b0001 << st_off;
            st_wdata = {4{st_data[7:0]}};
         end
         MEM_H: begin
            st_be    = st_off[1] ? 4'b1100 : 4'b0011;
            st_wdata = {2{st_data[15:0]}};
         end
         MEM_W:   st_be = 4'b1111;
         default: st_be = 4'b0000;
      endcase
   end

   always_comb begin
      ld_shift = ld_word >> {ld_off, 3'b000};
      case (ld_size)
         MEM_B:   ld_data = {{24{ld_sign & ld_shift[7]}}, ld_shift[7:0]};
         MEM_H:   ld_data = {{16{ld_sign & ld_shift[15]}}, ld_shift[15:0]};
         default: ld_data = ld_shift;
      endcase
   end

endmodule

// File: rtl/lsu_mem_ctrl.sv
// Load/store unit: runs one request/response bus transaction per memory instruction
// and stalls the core until it completes, times out, or is rejected as misaligned.
//
// state   | meaning
// IDLE    | no transaction; aligned access starts one, misaligned one pulses misalign
// REQ     | bus_req high with latched address/enables/data, waiting for bus_gnt
// WAIT    | granted, waiting for bus_rvalid
// DONE    | one cycle, stall low, rdata/bus_err presented to the core
module lsu_mem_ctrl
   import lsu_mem_ctrl_pkg::*;
#(
   parameter int ADDR_W         = 32,
   parameter int DATA_W         = 32,
   parameter int TIMEOUT_CYCLES = 64
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              load_en,
   input  logic              mem_write,
   input  logic [1:0]        mem_size,
   input  logic              ext_sign,
   input  logic [ADDR_W-1:0] addr,
   input  logic [DATA_W-1:0] wdata,
   output logic              stall,
   output logic [DATA_W-1:0] rdata,
   output logic              misalign,
   output logic              bus_err,
   output logic              bus_req,
   output logic              bus_we,
   output logic [ADDR_W-1:0] bus_addr,
   output logic [3:0]        bus_be,
   output logic [DATA_W-1:0] bus_wdata,
   input  logic              bus_gnt,
   input  logic              bus_rvalid,
   input  logic [DATA_W-1:0] bus_rdata
);

   localparam int               CNT_W    = $clog2(TIMEOUT_CYCLES);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

   lsu_state_e        state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              we_q, we_d;
   logic [ADDR_W-3:0] waddr_q, waddr_d;
   logic [3:0]        be_q, be_d;
   logic [DATA_W-1:0] wdata_q, wdata_d;
   logic [DATA_W-1:0] word_q, word_d;
   logic [1:0]        off_q, off_d;
   logic [1:0]        size_q, size_d;
   logic              sign_q, sign_d;
   logic              err_q, err_d;

   logic              access;
   logic              bad;
   logic              start;
   logic [3:0]        lane_be;
   logic [DATA_W-1:0] lane_wdata;
   logic [DATA_W-1:0] ld_data;

   assign access = load_en | mem_write;
   assign bad    = is_misaligned(mem_size, addr[1:0]);
   assign start  = access & ~bad;

   // Store side sees the live instruction; load side sees the latched access.
   lsu_lane_align u_lane_align (
      .st_size  (mem_size),
      .st_off   (addr[1:0]),
      .st_data  (wdata),
      .st_be    (lane_be),
      .st_wdata (lane_wdata),
      .ld_size  (size_q),
      .ld_off   (off_q),
      .ld_sign  (sign_q),
      .ld_word  (word_q),
      .ld_data  (ld_data)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         we_q    <= 1'b0;
         waddr_q <= '0;
         be_q    <= '0;
         wdata_q <= '0;
         word_q  <= '0;
         off_q   <= '0;
         size_q  <= '0;
         sign_q  <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         we_q    <= we_d;
         waddr_q <= waddr_d;
         be_q    <= be_d;
         wdata_q <= wdata_d;
         word_q  <= word_d;
         off_q   <= off_d;
         size_q  <= size_d;
         sign_q  <= sign_d;
         err_q   <= err_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      we_d    = we_q;
      waddr_d = waddr_q;
      be_d    = be_q;
      wdata_d = wdata_q;
      word_d  = word_q;
      off_d   = off_q;
      size_d  = size_q;
      sign_d  = sign_q;
      err_d   = err_q;
      case (state_q)
         ST_IDLE: begin
            if (start) begin
               we_d    = mem_write;
               waddr_d = addr[ADDR_W-1:2];
               be_d    = lane_be;
               wdata_d = mem_write ? lane_wdata : '0;
               off_d   = addr[1:0];
               size_d  = mem_size;
               sign_d  = ext_sign;
               word_d  = '0;
               err_d   = 1'b0;
               cnt_d   = '0;
               state_d = ST_REQ;
            end
         end
         ST_REQ: begin
            if (bus_gnt) begin
               cnt_d   = '0;
               state_d = ST_WAIT;
            end else if (cnt_q == CNT_LAST) begin
               err_d   = 1'b1;
               state_d = ST_DONE;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         ST_WAIT: begin
            if (bus_rvalid) begin
               word_d  = bus_rdata;
               state_d = ST_DONE;
            end else if (cnt_q == CNT_LAST) begin
               err_d   = 1'b1;
               state_d = ST_DONE;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // stall and misalign are decoded from live inputs, so reset must mask them.
   always_comb begin
      stall     = 1'b0;
      misalign  = 1'b0;
      rdata     = '0;
      bus_err   = 1'b0;
      bus_req   = 1'b0;
      bus_we    = we_q;
      bus_addr  = {waddr_q, 2'b00};
      bus_be    = be_q;
      bus_wdata = wdata_q;
      case (state_q)
         ST_IDLE: begin
            stall    = rst_n & start;
            misalign = rst_n & access & bad;
         end
         ST_REQ: begin
            stall   = 1'b1;
            bus_req = 1'b1;
         end
         ST_WAIT: stall = 1'b1;
         default: begin
            bus_err = err_q;
            rdata   = (we_q || err_q) ? '0 : ld_data;
         end
      endcase
   end

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// Directed bench for lsu_mem_ctrl with a transaction-level reference model and per-cycle compare.
module tb_lsu_mem_ctrl;

   localparam int TIMEOUT = 64;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        load_en = 1'b0, mem_write = 1'b0, ext_sign = 1'b0;
   logic [1:0]  mem_size = 2'b00;
   logic [31:0] addr = '0, wdata = '0;
   logic        stall, misalign, bus_err, bus_req, bus_we;
   logic [31:0] rdata, bus_addr, bus_wdata;
   logic [3:0]  bus_be;
   logic        bus_gnt = 1'b0, bus_rvalid = 1'b0;
   logic [31:0] bus_rdata = '0;

   lsu_mem_ctrl #(.ADDR_W(32), .DATA_W(32), .TIMEOUT_CYCLES(TIMEOUT)) dut (
      .clk(clk), .rst_n(rst_n), .load_en(load_en), .mem_write(mem_write),
      .mem_size(mem_size), .ext_sign(ext_sign), .addr(addr), .wdata(wdata),
      .stall(stall), .rdata(rdata), .misalign(misalign), .bus_err(bus_err),
      .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr), .bus_be(bus_be),
      .bus_wdata(bus_wdata), .bus_gnt(bus_gnt), .bus_rvalid(bus_rvalid),
      .bus_rdata(bus_rdata)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic bad_access(input logic [1:0] sz, input logic [1:0] off);
      if (sz == 2'd3) return 1'b1;
      if (sz == 2'd2) return off != 2'd0;
      if (sz == 2'd1) return (off % 2) == 1;
      return 1'b0;
   endfunction

   function automatic logic [3:0] lanes(input logic [1:0] sz, input logic [1:0] off);
      if (sz == 2'd0) return 4'(1 << off);
      if (sz == 2'd1) return (off >= 2'd2) ? 4'hC : 4'h3;
      return 4'hF;
   endfunction

   function automatic logic [31:0] replicate(input logic [1:0] sz, input logic [31:0] d);
      if (sz == 2'd0) return (d & 32'hFF) * 32'h01010101;
      if (sz == 2'd1) return (d & 32'hFFFF) * 32'h00010001;
      return d;
   endfunction

   function automatic logic [31:0] extract(input logic [31:0] w, input logic [1:0] sz,
                                           input logic [1:0] off, input logic sg);
      logic [31:0] s;
      s = w >> (8 * off);
      if (sz == 2'd0) begin
         s = s & 32'hFF;
         if (sg && s >= 32'h80) s = s - 32'h100;
      end else if (sz == 2'd1) begin
         s = s & 32'hFFFF;
         if (sg && s >= 32'h8000) s = s - 32'h10000;
      end
      return s;
   endfunction

   // Reference model: one outstanding access, tracked as busy/granted/finished plus elapsed cycles.
   logic        m_busy = 0, m_gnt = 0, m_fin = 0, m_err = 0, m_we = 0, m_sg = 0;
   logic [1:0]  m_sz = 0, m_off = 0;
   logic [31:0] m_addr = 0, m_wd = 0, m_word = 0;
   logic [3:0]  m_be = 0;
   int          m_elapsed = 0;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_busy <= 0; m_gnt <= 0; m_fin <= 0; m_err <= 0; m_we <= 0;
         m_elapsed <= 0; m_word <= 0;
      end else if (m_fin) begin
         m_fin <= 0;
      end else if (!m_busy) begin
         if ((load_en || mem_write) && !bad_access(mem_size, addr[1:0])) begin
            m_busy <= 1; m_gnt <= 0; m_err <= 0; m_elapsed <= 0; m_word <= 0;
            m_we   <= mem_write;
            m_sz   <= mem_size; m_off <= addr[1:0]; m_sg <= ext_sign;
            m_addr <= addr & 32'hFFFF_FFFC;
            m_be   <= lanes(mem_size, addr[1:0]);
            m_wd   <= mem_write ? replicate(mem_size, wdata) : 32'h0;
         end
      end else if (!m_gnt && bus_gnt) begin
         m_gnt <= 1; m_elapsed <= 0;
      end else if (m_gnt && bus_rvalid) begin
         m_word <= bus_rdata; m_busy <= 0; m_fin <= 1;
      end else if (m_elapsed + 1 == TIMEOUT) begin
         m_err <= 1; m_busy <= 0; m_fin <= 1;
      end else begin
         m_elapsed <= m_elapsed + 1;
      end
   end

   always @(negedge clk) begin
      logic        e_stall, e_req, e_mis, e_err, chk_rd;
      logic [31:0] e_rdata;
      e_stall = 0; e_req = 0; e_mis = 0; e_err = 0; chk_rd = 0; e_rdata = 0;
      if (rst_n) begin
         if (m_fin) begin
            e_err   = m_err;
            e_rdata = (m_err || m_we) ? 32'h0 : extract(m_word, m_sz, m_off, m_sg);
            chk_rd  = 1;
         end else if (m_busy) begin
            e_stall = 1;
            e_req   = !m_gnt;
         end else if (load_en || mem_write) begin
            if (bad_access(mem_size, addr[1:0])) begin
               e_mis  = 1;
               chk_rd = 1;
            end else begin
               e_stall = 1;
            end
         end
      end
      check("stall", stall, e_stall);
      check("bus_req", bus_req, e_req);
      check("misalign", misalign, e_mis);
      check("bus_err", bus_err, e_err);
      if (e_req) begin
         check("bus_addr", bus_addr, m_addr);
         check("bus_be", bus_be, m_be);
         check("bus_wdata", bus_wdata, m_wd);
         check("bus_we", bus_we, m_we);
      end
      if (chk_rd) check("rdata", rdata, e_rdata);
   end

   // Results of the last run_access call.
   int          r_stall, r_req;
   logic        r_issue, r_err, r_we;
   logic [31:0] r_rdata, r_addr, r_wd;
   logic [3:0]  r_be;

   // Entered and left one time unit after a rising edge. gdly/rdly = idle cycles
   // before gnt/rvalid in REQ/WAIT; a negative value never responds.
   task automatic run_access(input logic ld, input logic st, input logic [1:0] sz,
                             input logic sg, input logic [31:0] a, input logic [31:0] wd,
                             input logic [31:0] rword, input int gdly, input int rdly);
      int  ph, rc, wc;
      logic done, got;
      load_en = ld; mem_write = st; mem_size = sz; ext_sign = sg; addr = a; wdata = wd;
      r_stall = 0; r_req = 0; r_err = 0; r_rdata = 32'hX; got = 0; done = 0;
      ph = 0; rc = 0; wc = 0;
      @(negedge clk);
      r_issue = stall;
      @(posedge clk); #1;
      for (int c = 0; c < 200; c++) begin
         bus_gnt    = (ph == 0 && gdly >= 0 && rc == gdly);
         bus_rvalid = (ph == 1 && rdly >= 0 && wc == rdly);
         bus_rdata  = bus_rvalid ? rword : 32'hDEAD_BEEF;
         @(negedge clk);
         if (bus_req) begin
            r_req++;
            if (!got) begin
               r_addr = bus_addr; r_be = bus_be; r_wd = bus_wdata; r_we = bus_we; got = 1;
            end
         end
         if (stall) r_stall++;
         else begin
            r_rdata = rdata; r_err = bus_err; done = 1;
         end
         @(posedge clk);
         if (ph == 0) begin
            if (bus_gnt) ph = 1; else rc++;
         end else begin
            wc++;
         end
         #1;
         if (done) break;
      end
      if (!done) check("access_completes", 32'd0, 32'd1);
      bus_gnt = 0; bus_rvalid = 0; load_en = 0; mem_write = 0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not end in time");
      $fatal(1);
   end

   initial begin
      rst_n = 0;
      repeat (3) @(posedge clk);
      #1;
      load_en = 1; mem_size = 2'b11; addr = 32'h0000_0001;
      #1;
      check("rst_stall", stall, 0);
      check("rst_misalign", misalign, 0);
      check("rst_bus_req", bus_req, 0);
      check("rst_bus_addr", bus_addr, 0);
      check("rst_bus_be", bus_be, 0);
      check("rst_rdata", rdata, 0);
      load_en = 0; mem_size = 0; addr = 0;
      #1 rst_n = 1;
      @(posedge clk); #1;

      // store byte, fastest handshake
      run_access(0, 1, 2'b00, 0, 32'h1003, 32'h0000_00AB, 32'h0, 0, 0);
      check("sb_issue_stall", r_issue, 1);
      check("sb_addr", r_addr, 32'h1000);
      check("sb_be", r_be, 4'b1000);
      check("sb_wdata", r_wd, 32'hABAB_ABAB);
      check("sb_we", r_we, 1);
      check("sb_stall_cycles", r_stall, 2);
      check("sb_rdata", r_rdata, 0);

      // load half signed and unsigned
      run_access(1, 0, 2'b01, 1, 32'h2002, 32'h0, 32'h8001_1234, 0, 0);
      check("lh_be", r_be, 4'b1100);
      check("lh_wdata", r_wd, 0);
      check("lh_rdata", r_rdata, 32'hFFFF_8001);
      run_access(1, 0, 2'b01, 0, 32'h2002, 32'h0, 32'h8001_1234, 0, 0);
      check("lhu_rdata", r_rdata, 32'h0000_8001);

      // wait states: gnt in third REQ cycle, rvalid in second WAIT cycle
      run_access(1, 0, 2'b00, 1, 32'h5001, 32'h0, 32'hCAFE_F00D, 2, 1);
      check("lb_wait_req_cycles", r_req, 3);
      check("lb_wait_stall_cycles", r_stall, 5);
      check("lb_wait_rdata", r_rdata, 32'hFFFF_FFF0);
      run_access(0, 1, 2'b01, 0, 32'h6002, 32'h1234_BEEF, 32'h0, 1, 2);
      check("sh_wait_be", r_be, 4'b1100);
      check("sh_wait_wdata", r_wd, 32'hBEEF_BEEF);
      check("sh_wait_stall_cycles", r_stall, 5);

      // load and store together are a store
      run_access(1, 1, 2'b10, 0, 32'h8004, 32'h1122_3344, 32'hFFFF_FFFF, 0, 0);
      check("ls_we", r_we, 1);
      check("ls_wdata", r_wd, 32'h1122_3344);
      check("ls_rdata", r_rdata, 0);

      // misaligned word and illegal size
      load_en = 1; mem_size = 2'b10; addr = 32'h3002;
      #1;
      check("mis_word", misalign, 1);
      check("mis_word_stall", stall, 0);
      check("mis_word_req", bus_req, 0);
      @(posedge clk); #1;
      mem_size = 2'b11; addr = 32'h3000;
      #1;
      check("mis_size", misalign, 1);
      check("mis_size_stall", stall, 0);
      check("mis_size_rdata", rdata, 0);
      @(posedge clk); #1;
      load_en = 0;
      @(negedge clk);
      check("mis_no_req", bus_req, 0);
      @(posedge clk); #1;

      // timeout waiting for grant, then for response
      run_access(1, 0, 2'b10, 0, 32'h7000, 32'h0, 32'h0, -1, 0);
      check("to_req_cycles", r_req, TIMEOUT);
      check("to_stall_cycles", r_stall, TIMEOUT);
      check("to_bus_err", r_err, 1);
      check("to_rdata", r_rdata, 0);
      @(negedge clk);
      check("to_idle_stall", stall, 0);
      check("to_idle_req", bus_req, 0);
      @(posedge clk); #1;
      run_access(1, 0, 2'b10, 0, 32'h7004, 32'h0, 32'h0, 0, -1);
      check("tow_stall_cycles", r_stall, TIMEOUT + 1);
      check("tow_bus_err", r_err, 1);

      // asynchronous reset while waiting for the response
      load_en = 1; mem_size = 2'b10; addr = 32'h9000; ext_sign = 0;
      @(posedge clk); #1;
      bus_gnt = 1;
      @(posedge clk); #1;
      bus_gnt = 0;
      @(negedge clk);
      check("rw_stall_before", stall, 1);
      #2 rst_n = 0;
      #1;
      check("rw_bus_req", bus_req, 0);
      check("rw_stall", stall, 0);
      check("rw_bus_err", bus_err, 0);
      check("rw_bus_addr", bus_addr, 0);
      load_en = 0;
      repeat (2) @(posedge clk);
      #3 rst_n = 1;
      @(posedge clk); #1;
      bus_rvalid = 1; bus_rdata = 32'h5555_5555;
      @(negedge clk);
      check("late_rvalid_stall", stall, 0);
      check("late_rvalid_req", bus_req, 0);
      @(posedge clk); #1;
      bus_rvalid = 0;
      run_access(1, 0, 2'b10, 0, 32'h0000_0040, 32'h0, 32'h1234_5678, 0, 0);
      check("post_rst_rdata", r_rdata, 32'h1234_5678);
      check("post_rst_stall_cycles", r_stall, 2);
      check("post_rst_addr", r_addr, 32'h0000_0040);

      repeat (2) @(posedge clk);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
